// File: rtl/router_pkt_tx_pkg.sv
// rtl/router_pkt_tx_pkg.sv - shared types and header field layout for the router packet transmitter
package router_pkt_tx_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;
  localparam int BUF_DEPTH = 1 << LEN_W;

  localparam logic [ADDR_W-1:0] INVALID_DEST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  function automatic logic [DATA_W-1:0] make_header(input logic [ADDR_W-1:0] dest,
                                                    input logic [LEN_W-1:0] len);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - 64x8 payload buffer, synchronous write, combinational read
module router_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are always written before being read, so no reset is needed.
  logic [DATA_W-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers a payload, then streams header, payload and parity to a router port
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_dest,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic              done,
  output logic              cfg_err
);

  // GAP_CYCLES must be at least 1; the gap counter runs 0..GAP_CYCLES-1.
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  index;
  logic [DATA_W-1:0] parity;
  logic [7:0]        gap_cnt;
  logic              buf_wr;
  logic [DATA_W-1:0] buf_rd;
  logic [DATA_W-1:0] header;
  logic [LEN_W-1:0]  len_last;
  logic              req_bad;

  assign header   = make_header(dest_q, len_q);
  assign len_last = len_q - 6'd1;
  assign req_bad  = (req_dest == INVALID_DEST) || (req_len == '0);

  router_tx_buf u_buf (
    .clock   (clock),
    .wr_en   (buf_wr),
    .wr_addr (count),
    .wr_data (pl_data),
    .rd_addr (index),
    .rd_data (buf_rd)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stream outputs decode from state only, so they hold naturally while busy is high.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    buf_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_bad) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        pl_ready = 1'b1;
        buf_wr   = pl_valid;
        if (pl_valid && count == len_last) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        pkt_valid = 1'b1;
        pkt_data  = header;
        if (!busy) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pkt_valid = 1'b1;
        pkt_data  = buf_rd;
        if (!busy && index == len_last) state_nxt = S_PARITY;
      end
      S_PARITY: begin
        pkt_data = parity;
        if (!busy) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dest_q  <= '0;
      len_q   <= '0;
      count   <= '0;
      index   <= '0;
      parity  <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              cfg_err <= 1'b1;
            end else begin
              dest_q <= req_dest;
              len_q  <= req_len;
              count  <= '0;
            end
          end
        end
        S_LOAD: begin
          if (pl_valid) count <= count + 6'd1;
        end
        S_HEADER: begin
          if (!busy) begin
            parity <= header;
            index  <= '0;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            parity <= parity ^ buf_rd;
            index  <= index + 6'd1;
          end
        end
        S_PARITY: begin
          if (!busy) begin
            done    <= 1'b1;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed scoreboard bench for router_pkt_tx
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic [1:0] req_dest;
  logic [5:0] req_len;
  logic       req_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       done;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [64];
  logic [8:0] sb_q [$];

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_len   (req_len),
    .req_ready (req_ready),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_req(input logic [1:0] dest, input logic [5:0] len);
    req_valid = 1'b1;
    req_dest  = dest;
    req_len   = len;
    @(negedge clock);
    chk("req_ready_idle", {8'd0, req_ready}, 9'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic load_payload(input logic [5:0] len);
    for (int i = 0; i < int'(len); i++) begin
      pl_valid  = 1'b1;
      pl_data   = pay[i];
      req_valid = 1'b1;
      @(negedge clock);
      chk("pl_ready_load", {8'd0, pl_ready}, 9'd1);
      chk("req_ready_busy", {8'd0, req_ready}, 9'd0);
      step();
    end
    pl_valid  = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [1:0] dest, input logic [5:0] len,
                             input logic [127:0] busy_mask);
    logic [7:0] hdr;
    logic [7:0] par;
    int k;
    hdr = {len, dest};
    par = hdr;
    issue_req(dest, len);
    sb_q.push_back({1'b1, hdr});
    for (int i = 0; i < int'(len); i++) begin
      sb_q.push_back({1'b1, pay[i]});
      par = par ^ pay[i];
    end
    sb_q.push_back({1'b0, par});
    load_payload(len);
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      busy = (k < 128) ? busy_mask[k] : 1'b0;
      @(negedge clock);
      chk("stream_byte", {pkt_valid, pkt_data}, sb_q[0]);
      if (!busy) void'(sb_q.pop_front());
      step();
      k++;
    end
    busy = 1'b0;
    chk("stream_drained", 9'(sb_q.size()), 9'd0);
    sb_q.delete();
    @(negedge clock);
    chk("done_pulse", {8'd0, done}, 9'd1);
    chk("gap_out_zero", {pkt_valid, pkt_data}, 9'd0);
    chk("gap1_not_ready", {8'd0, req_ready}, 9'd0);
    step();
    @(negedge clock);
    chk("done_single", {8'd0, done}, 9'd0);
    chk("gap2_not_ready", {8'd0, req_ready}, 9'd0);
    step();
    @(negedge clock);
    chk("idle_ready", {8'd0, req_ready}, 9'd1);
    step();
  endtask

  task automatic bad_req(input logic [1:0] dest, input logic [5:0] len);
    issue_req(dest, len);
    @(negedge clock);
    chk("cfg_err_pulse", {8'd0, cfg_err}, 9'd1);
    chk("cfg_err_ready", {8'd0, req_ready}, 9'd1);
    chk("cfg_err_no_pkt", {8'd0, pkt_valid}, 9'd0);
    step();
    @(negedge clock);
    chk("cfg_err_single", {8'd0, cfg_err}, 9'd0);
    chk("cfg_err_still_idle", {8'd0, req_ready}, 9'd1);
    step();
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_dest  = '0;
    req_len   = '0;
    pl_data   = '0;
    pl_valid  = 1'b0;
    busy      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", {8'd0, req_ready}, 9'd1);
    chk("rst_pl_ready", {8'd0, pl_ready}, 9'd0);
    chk("rst_pkt", {pkt_valid, pkt_data}, 9'd0);
    chk("rst_done", {8'd0, done}, 9'd0);
    chk("rst_cfg_err", {8'd0, cfg_err}, 9'd0);
    step();

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_packet(2'd1, 6'd3, 128'h0);
    send_packet(2'd1, 6'd3, 128'hC);
    send_packet(2'd1, 6'd3, 128'hF);

    bad_req(2'd3, 6'd5);
    bad_req(2'd0, 6'd0);

    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    send_packet(2'd2, 6'd63, 128'h0);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    issue_req(2'd1, 6'd3);
    load_payload(6'd3);
    busy = 1'b0;
    step();
    step();
    @(negedge clock);
    chk("mid_payload_idx1", {pkt_valid, pkt_data}, {1'b1, 8'h22});
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_pkt", {pkt_valid, pkt_data}, 9'd0);
    step();
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", {8'd0, req_ready}, 9'd1);
    chk("post_rst_pl_ready", {8'd0, pl_ready}, 9'd0);
    step();
    send_packet(2'd1, 6'd3, 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
